imem_line_responder: RTL and testbench
======================================

Name: imem_line_responder

Overview:
- Responder for the core's instruction-memory port: the other end of imem_addr / imem_rmask / imem_resp.
- Serves instruction reads from a small direct-mapped line buffer.
- On a miss, fills the whole line from a backing-memory read port (dfp_*).
- Sits between the fetch stage and the memory subsystem; read-only, no write path.

Parameters:
NUM_LINES, 4, number of direct-mapped lines; power of 2, >=1
LINE_WORDS, 4, 32-bit words per line; power of 2, >=2

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
imem_addr  in  32  fetch byte address; bits [1:0] ignored
imem_rmask  in  4  nonzero = read request this cycle; any nonzero value reads the full word
imem_rdata  out  32  instruction word, valid only when imem_resp=1
imem_resp  out  1  one-cycle pulse, response to the oldest accepted request
inv  in  1  invalidate all lines (fence.i)
dfp_addr  out  32  line-aligned fill address
dfp_read  out  1  fill request; held high until dfp_resp
dfp_rdata  in  32*LINE_WORDS  fill line; word i at bits [32i+31:32i]
dfp_resp  in  1  fill data valid, single-cycle pulse

Behaviour:
- Address split:
  - offset = addr[log2(LINE_WORDS)+1:2]
  - index = next log2(NUM_LINES) bits (no index field when NUM_LINES=1)
  - tag = remaining upper bits
- Per-line state: valid bit, tag, LINE_WORDS*32 data.
- Reset (rst_n=0 at posedge), from any state including mid-fill:
  - all valid=0, state=IDLE
  - imem_resp=0, imem_rdata=0, dfp_read=0, dfp_addr=0
  - a dfp_resp arriving after reset is ignored.
- States:
  - IDLE:
    - Request = imem_rmask != 0.
    - Hit (valid and tag match): next cycle imem_resp=1, imem_rdata = selected word, stay IDLE. One request per cycle is sustained on back-to-back hits.
    - Miss: latch addr; next cycle dfp_read=1, dfp_addr = {addr[31:offset_msb+1], zeros}; go FILL.
  - FILL:
    - dfp_read held high and dfp_addr held stable.
    - imem_rmask/imem_addr are ignored; the core holds its request, and any change does not alter the fill.
    - On dfp_resp: write the line, set valid, dfp_read=0 next cycle, go DONE.
  - DONE (one cycle):
    - imem_resp=1, imem_rdata = word of the latched address.
    - Requests this cycle are ignored; go IDLE.
- imem_resp is 0 in every cycle not listed above. imem_rdata holds its last value when imem_resp=0.
- Latency:
  - Hit: 1 cycle (request at N, resp at N+1).
  - Miss: dfp_read rises at N+1. With dfp_resp at cycle M, imem_resp=1 at M+1.
- Flush / redirect during FILL: the fill always completes, and the DONE response carries the latched address's word. The core discards it and re-requests. No abort path.
- inv:
  - Clears all valid bits at the next posedge, in any state.
  - In IDLE, inv takes priority: a request in the same cycle is treated as a miss.
  - inv during FILL clears the other lines; the filling line is still written valid on dfp_resp.
  - inv in the same cycle as dfp_resp: the line is written with valid=0 and DONE still returns the data.
- Conflicting lines (same index, different tag) replace each other. No replacement choice.
- Address wrap: 0xFFFFFFFC maps normally; no carry into other lines.

Test Plan:
1. Reset then request 0x60000000, backing line {w3..w0} = {0x00000013,0x00100093,0x00200113,0x00300193} with dfp_resp 3 cycles later -> dfp_read=1 with dfp_addr=0x60000000 one cycle after request, imem_resp=1 with rdata=0x00300193 one cycle after dfp_resp, no other resp pulses.
2. After test 1, request 0x60000004, 0x60000008, 0x6000000C on consecutive cycles -> three consecutive resp pulses with 0x00200113, 0x00100093, 0x00000013; dfp_read stays 0.
3. After test 1, request 0x60000040 (same index, new tag) -> miss fill at dfp_addr 0x60000040. Then 0x60000000 -> misses again (line replaced).
4. Miss at 0x60000010; during FILL change imem_addr to 0x60000100 -> dfp_addr stays 0x60000010; DONE returns word 0 of the 0x60000010 line. Next request to 0x60000100 -> new miss.
5. After test 2, pulse inv together with a request to 0x60000000 -> treated as miss, dfp_read=1; no hit response.
6. Deassert rst_n during FILL, then deliver dfp_resp -> imem_resp stays 0 and dfp_read=0 after reset. Request 0x60000000 -> misses (valid cleared).

Source files
------------

// File: rtl/imem_line_responder.sv
// ----------------------------------------------------------------------------
// imem_line_responder
//
// Purpose: the responder on the fetch stage's instruction-memory port. A
// small direct-mapped line buffer serves the instruction reads. On a miss the
// whole line is fetched from a backing-memory read port. There is no write
// path.
//
// Ports:
//   clk          clock; all state updates on posedge
//   rst_n        synchronous active-low reset
//   imem_addr    fetch byte address (bits [1:0] ignored)
//   imem_rmask   nonzero = read request this cycle (always a full word)
//   imem_rdata   instruction word, valid while imem_resp=1, held otherwise
//   imem_resp    one-cycle response pulse for the oldest accepted request
//   inv          invalidate every line (fence.i)
//   dfp_addr     line-aligned fill address
//   dfp_read     fill request, held high until dfp_resp
//   dfp_rdata    fill line; word i at bits [32i+31:32i]
//   dfp_resp     single-cycle pulse, fill data valid
//
// Handshake: a request is accepted in any IDLE cycle where imem_rmask != 0.
// Exactly one imem_resp pulse follows for each accepted request. On a fill,
// dfp_read rises the cycle after the miss. dfp_read and dfp_addr stay
// constant until the first cycle that samples dfp_resp=1. dfp_read drops on
// the cycle after that.
// ----------------------------------------------------------------------------
module imem_line_responder #(
  parameter int NUM_LINES  = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               imem_addr,
  input  logic [3:0]                imem_rmask,
  output logic [31:0]               imem_rdata,
  output logic                      imem_resp,
  input  logic                      inv,
  output logic [31:0]               dfp_addr,
  output logic                      dfp_read,
  input  logic [32*LINE_WORDS-1:0]  dfp_rdata,
  input  logic                      dfp_resp
);

  localparam int OFF_W    = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  // A single-line buffer has no index field. A 1-bit index that is always
  // zero keeps the declarations legal.
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int TAG_LSB  = 2 + OFF_W + IDX_BITS;
  localparam int TAG_W    = 32 - TAG_LSB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state;

  logic                      valid_q [NUM_LINES];
  logic [TAG_W-1:0]          tag_q   [NUM_LINES];
  logic [32*LINE_WORDS-1:0]  data_q  [NUM_LINES];

  // Fields of the missing address, captured when the fill starts.
  logic [TAG_W-1:0]          lat_tag;
  logic [IDX_W-1:0]          lat_idx;
  logic [OFF_W-1:0]          lat_off;

  logic [TAG_W-1:0]          req_tag;
  logic [IDX_W-1:0]          req_idx;
  logic [OFF_W-1:0]          req_off;
  logic                      req;
  logic                      hit;

  assign req_tag = imem_addr[31:TAG_LSB];
  assign req_off = imem_addr[OFF_W+1:2];

  generate
    if (IDX_BITS > 0) begin : g_idx
      assign req_idx = imem_addr[TAG_LSB-1:2+OFF_W];
    end else begin : g_no_idx
      assign req_idx = '0;
    end
  endgenerate

  // The byte-offset bits are unused because every read returns a full word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^imem_addr[1:0];

  assign req = (imem_rmask != 4'd0);
  assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_resp  <= 1'b0;
      imem_rdata <= 32'd0;
      dfp_read   <= 1'b0;
      dfp_addr   <= 32'd0;
      lat_tag    <= '0;
      lat_idx    <= '0;
      lat_off    <= '0;
      for (int i = 0; i < NUM_LINES; i++) valid_q[i] <= 1'b0;
    end else begin
      imem_resp <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            // When inv is high in the same cycle, the request must not hit.
            // The buffer is being invalidated, so the request becomes a miss.
            if (hit && !inv) begin
              imem_resp  <= 1'b1;
              imem_rdata <= data_q[req_idx][32*req_off +: 32];
            end else begin
              lat_tag  <= req_tag;
              lat_idx  <= req_idx;
              lat_off  <= req_off;
              dfp_read <= 1'b1;
              dfp_addr <= {imem_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
              state    <= FILL;
            end
          end
        end

        FILL: begin
          // The fetch inputs are ignored in this state. The fill always
          // completes for the latched address.
          if (dfp_resp) begin
            data_q[lat_idx]  <= dfp_rdata;
            tag_q[lat_idx]   <= lat_tag;
            valid_q[lat_idx] <= 1'b1;
            dfp_read         <= 1'b0;
            imem_resp        <= 1'b1;
            imem_rdata       <= dfp_rdata[32*lat_off +: 32];
            state            <= DONE;
          end
        end

        DONE: begin
          // The response is on the outputs during this cycle. Any request
          // seen in this cycle is dropped.
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // This clear comes after the case, so it overrides the line-valid set
      // done by a dfp_resp in the same cycle. That line is then left invalid.
      if (inv) begin
        for (int i = 0; i < NUM_LINES; i++) valid_q[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_line_responder.sv
// ----------------------------------------------------------------------------
// tb_imem_line_responder
//
// Directed bench for imem_line_responder with the default geometry: 4 lines
// of 4 words. Offset is addr[3:2], index is addr[5:4], tag is addr[31:6].
// Inputs are driven 1 ns after each posedge. Outputs are sampled at that
// same point, so they show the state left by the edge that just passed.
// ----------------------------------------------------------------------------
module tb_imem_line_responder;

  localparam int NUM_LINES  = 4;
  localparam int LINE_WORDS = 4;

  logic                      clk;
  logic                      rst_n;
  logic [31:0]               imem_addr;
  logic [3:0]                imem_rmask;
  logic [31:0]               imem_rdata;
  logic                      imem_resp;
  logic                      inv;
  logic [31:0]               dfp_addr;
  logic                      dfp_read;
  logic [32*LINE_WORDS-1:0]  dfp_rdata;
  logic                      dfp_resp;

  int checks;
  int failures;

  imem_line_responder #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .inv        (inv),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  // Driver tasks

  // Present one request. The caller expects a miss. After the edge, check
  // that the fill has started and that no response was given.
  task automatic start_miss(input string tag, input logic [31:0] addr, input logic [31:0] exp_dfp);
    imem_addr  = addr;
    imem_rmask = 4'hF;
    tick();
    imem_rmask = 4'h0;
    check({tag, "_noresp"}, {31'd0, imem_resp}, 32'd0);
    check({tag, "_dfp_read"}, {31'd0, dfp_read}, 32'd1);
    check({tag, "_dfp_addr"}, dfp_addr, exp_dfp);
  endtask

  // Stay in FILL for 'wait_cycles' cycles, then deliver the line and check
  // the DONE response. Finish by checking the quiet cycle after DONE.
  task automatic finish_fill(input string tag, input logic [127:0] line, input int wait_cycles,
                             input logic [31:0] exp_dfp, input logic [31:0] exp_word);
    for (int i = 0; i < wait_cycles; i++) begin
      tick();
      check({tag, "_wait_noresp"}, {31'd0, imem_resp}, 32'd0);
      check({tag, "_wait_dfp_read"}, {31'd0, dfp_read}, 32'd1);
      check({tag, "_wait_dfp_addr"}, dfp_addr, exp_dfp);
    end
    dfp_rdata = line;
    dfp_resp  = 1'b1;
    tick();
    dfp_resp  = 1'b0;
    dfp_rdata = '0;
    check({tag, "_done_resp"}, {31'd0, imem_resp}, 32'd1);
    check({tag, "_done_rdata"}, imem_rdata, exp_word);
    check({tag, "_done_dfp_read"}, {31'd0, dfp_read}, 32'd0);
    tick();
    check({tag, "_after_noresp"}, {31'd0, imem_resp}, 32'd0);
  endtask

  // Issue one request that must hit. Back-to-back calls give requests on
  // consecutive cycles.
  task automatic hit(input string tag, input logic [31:0] addr, input logic [31:0] exp_word);
    imem_addr  = addr;
    imem_rmask = 4'hF;
    tick();
    imem_rmask = 4'h0;
    check({tag, "_resp"}, {31'd0, imem_resp}, 32'd1);
    check({tag, "_rdata"}, imem_rdata, exp_word);
    check({tag, "_dfp_read"}, {31'd0, dfp_read}, 32'd0);
  endtask

  // Expected-data tables
  logic [127:0] line_a;  // 0x60000000
  logic [127:0] line_b;  // 0x60000040
  logic [127:0] line_c;  // 0x60000010
  logic [127:0] line_d;  // 0x60000100
  logic [127:0] line_e;  // 0x60000020
  logic [127:0] line_f;  // 0x60000030
  logic [127:0] line_g;  // 0xFFFFFFF0

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    imem_addr  = 32'd0;
    imem_rmask = 4'h0;
    inv        = 1'b0;
    dfp_rdata  = '0;
    dfp_resp   = 1'b0;

    line_a = line_of(32'h00300193, 32'h00200113, 32'h00100093, 32'h00000013);
    line_b = line_of(32'hB0000000, 32'hB0000001, 32'hB0000002, 32'hB0000003);
    line_c = line_of(32'hC0000000, 32'hC0000001, 32'hC0000002, 32'hC0000003);
    line_d = line_of(32'hD0000000, 32'hD0000001, 32'hD0000002, 32'hD0000003);
    line_e = line_of(32'hE0000000, 32'hE0000001, 32'hE0000002, 32'hE0000003);
    line_f = line_of(32'hF0000000, 32'hF0000001, 32'hF0000002, 32'hF0000003);
    line_g = line_of(32'h11110000, 32'h11110001, 32'h11110002, 32'h11110003);

    // Reset state
    tick();
    tick();
    check("rst_resp", {31'd0, imem_resp}, 32'd0);
    check("rst_rdata", imem_rdata, 32'd0);
    check("rst_dfp_read", {31'd0, dfp_read}, 32'd0);
    check("rst_dfp_addr", dfp_addr, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_resp", {31'd0, imem_resp}, 32'd0);

    // T1: cold miss. dfp_resp is sampled 3 cycles after the request edge.
    start_miss("t1", 32'h60000000, 32'h60000000);
    finish_fill("t1", line_a, 2, 32'h60000000, 32'h00300193);

    // T2: three back-to-back hits on the same line
    hit("t2_w1", 32'h60000004, 32'h00200113);
    hit("t2_w2", 32'h60000008, 32'h00100093);
    hit("t2_w3", 32'h6000000C, 32'h00000013);
    tick();
    check("t2_tail_noresp", {31'd0, imem_resp}, 32'd0);
    check("t2_tail_dfp_read", {31'd0, dfp_read}, 32'd0);

    // T5: inv together with a request to a valid line gives a miss
    imem_addr  = 32'h60000000;
    imem_rmask = 4'hF;
    inv        = 1'b1;
    tick();
    inv        = 1'b0;
    imem_rmask = 4'h0;
    check("t5_noresp", {31'd0, imem_resp}, 32'd0);
    check("t5_dfp_read", {31'd0, dfp_read}, 32'd1);
    check("t5_dfp_addr", dfp_addr, 32'h60000000);
    finish_fill("t5", line_a, 1, 32'h60000000, 32'h00300193);

    // T3: conflict at index 0 replaces the line
    start_miss("t3_new", 32'h60000040, 32'h60000040);
    finish_fill("t3_new", line_b, 1, 32'h60000040, 32'hB0000000);
    hit("t3_hit_b", 32'h60000048, 32'hB0000002);
    start_miss("t3_old", 32'h60000000, 32'h60000000);
    finish_fill("t3_old", line_a, 0, 32'h60000000, 32'h00300193);

    // T4: the fetch address changes mid-fill, but the fill does not change
    start_miss("t4", 32'h60000010, 32'h60000010);
    imem_addr  = 32'h60000100;
    imem_rmask = 4'hF;
    tick();
    check("t4_held_dfp_addr", dfp_addr, 32'h60000010);
    check("t4_held_noresp", {31'd0, imem_resp}, 32'd0);
    imem_rmask = 4'h0;
    finish_fill("t4", line_c, 1, 32'h60000010, 32'hC0000000);
    start_miss("t4_redirect", 32'h60000100, 32'h60000100);
    finish_fill("t4_redirect", line_d, 0, 32'h60000100, 32'hD0000000);

    // inv during FILL: the filling line still becomes valid, other lines are cleared
    start_miss("invfill", 32'h60000024, 32'h60000020);
    inv = 1'b1;
    tick();
    inv = 1'b0;
    check("invfill_dfp_read", {31'd0, dfp_read}, 32'd1);
    finish_fill("invfill", line_e, 0, 32'h60000020, 32'hE0000001);
    hit("invfill_kept", 32'h6000002C, 32'hE0000003);
    start_miss("invfill_other", 32'h60000010, 32'h60000010);
    finish_fill("invfill_other", line_c, 0, 32'h60000010, 32'hC0000000);

    // inv in the same cycle as dfp_resp: data is returned, line left invalid
    start_miss("invresp", 32'h60000038, 32'h60000030);
    dfp_rdata = line_f;
    dfp_resp  = 1'b1;
    inv       = 1'b1;
    tick();
    dfp_resp  = 1'b0;
    inv       = 1'b0;
    dfp_rdata = '0;
    check("invresp_resp", {31'd0, imem_resp}, 32'd1);
    check("invresp_rdata", imem_rdata, 32'hF0000002);
    tick();
    start_miss("invresp_again", 32'h60000038, 32'h60000030);
    finish_fill("invresp_again", line_f, 0, 32'h60000030, 32'hF0000002);

    // Address wrap: the top word maps to the last line
    start_miss("wrap", 32'hFFFFFFFC, 32'hFFFFFFF0);
    finish_fill("wrap", line_g, 1, 32'hFFFFFFF0, 32'h11110003);
    hit("wrap_hit", 32'hFFFFFFF0, 32'h11110000);

    // T6: reset during FILL. The late dfp_resp is ignored and valid bits are cleared.
    start_miss("t6_pre", 32'h60000000, 32'h60000000);
    finish_fill("t6_pre", line_a, 0, 32'h60000000, 32'h00300193);
    hit("t6_pre_hit", 32'h60000004, 32'h00200113);
    start_miss("t6", 32'h60000020, 32'h60000020);
    rst_n = 1'b0;
    tick();
    check("t6_rst_dfp_read", {31'd0, dfp_read}, 32'd0);
    check("t6_rst_noresp", {31'd0, imem_resp}, 32'd0);
    rst_n     = 1'b1;
    dfp_rdata = line_e;
    dfp_resp  = 1'b1;
    tick();
    dfp_resp  = 1'b0;
    dfp_rdata = '0;
    check("t6_late_noresp", {31'd0, imem_resp}, 32'd0);
    check("t6_late_dfp_read", {31'd0, dfp_read}, 32'd0);
    tick();
    check("t6_late2_noresp", {31'd0, imem_resp}, 32'd0);
    start_miss("t6_post", 32'h60000000, 32'h60000000);
    finish_fill("t6_post", line_a, 0, 32'h60000000, 32'h00300193);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
